packet_frame_ctrl: RTL and testbench

Sequences the UART byte stream from the eDVS receiver into 32-bit SpiNNaker event packets.
- Counts byte strobes from the UART receiver and packs bytes into a word.
- Enforces an inter-byte timeout and resynchronises on framing errors or stalls.
- Buffers completed packets in a small FIFO and presents them downstream with a valid/ready handshake.
- Sits between the UART receiver and the SpiNNaker link transmitter.

---
 rtl/packet_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_packet_frame_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/packet_frame_ctrl.sv
// packet_frame_ctrl: packs UART bytes from the eDVS receiver into 32-bit
// SpiNNaker event packets, guards the inter-byte gap with a timeout and
// queues finished packets in a small first-word-fall-through FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first byte of a packet
// COLLECT | packet in progress, inter-byte timer running
// COMMIT  | one cycle: push assembled word to FIFO or count it dropped
module packet_frame_ctrl #(
  parameter int BYTES_PER_PKT = 4,
  parameter int TIMEOUT_CYC   = 1024,
  parameter int FIFO_DEPTH    = 4,
  parameter bit MSB_FIRST     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          byte_vld,
  input  logic [7:0]                    byte_data,
  input  logic                          frame_err,
  output logic                          pkt_valid,
  output logic [31:0]                   pkt_data,
  input  logic                          pkt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt,
  output logic                          resync,
  output logic                          busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int CW = $clog2(BYTES_PER_PKT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTES_PER_PKT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   timer_q;
  logic [31:0]     word_q, word_shift;
  logic            accept, discard, commit;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [LW-1:0]   level_q, level_d;
  logic            pop, push, full, drop;
  logic [31:0]     head_d;

  // the shift direction decides which end of the word the first byte lands in
  assign word_shift = MSB_FIRST ? {word_q[23:0], byte_data} : {byte_data, word_q[31:8]};
  assign busy       = (state_q != S_IDLE);
  assign fifo_level = level_q;

  // next-state decode; a byte in the timeout cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    discard = 1'b0;
    commit  = (state_q == S_COMMIT);
    case (state_q)
      S_IDLE: begin
        if (byte_vld && !frame_err) begin
          accept  = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (byte_vld) begin
          if (frame_err) begin
            discard = 1'b1;
            state_d = S_IDLE;
          end else begin
            accept = 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_COMMIT;
          end
        end else if (timer_q == TO_LAST) begin
          discard = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (byte_vld && !frame_err) begin
          accept  = 1'b1;
          state_d = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, byte counter, inter-byte timer and word assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      word_q  <= '0;
      resync  <= 1'b0;
    end else begin
      state_q <= state_d;
      resync  <= discard;
      if (accept) word_q <= word_shift;
      if (state_d == S_IDLE) begin
        cnt_q   <= '0;
        timer_q <= '0;
      end else if (accept) begin
        timer_q <= '0;
        cnt_q   <= (state_q == S_COLLECT) ? cnt_q + CW'(1) : CW'(1);
      end else begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

  // FIFO control; a pop in the commit cycle frees room in a full FIFO
  always_comb begin
    pop     = pkt_valid && pkt_ready;
    full    = (level_q == LW'(FIFO_DEPTH));
    push    = commit && (!full || pop);
    drop    = commit && !push;
    rd_nxt  = rd_ptr_q + PW'(1);
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    head_d = pkt_data;
    if (pop) begin
      if (level_q > LW'(1)) head_d = mem[rd_nxt];
      else if (push)        head_d = word_q;
    end else if (level_q == '0 && push) begin
      head_d = word_q;
    end
  end

  // packet storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= word_q;
  end

  // pointers, level, registered head and drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
      level_q   <= level_d;
      pkt_valid <= (level_d != '0);
      pkt_data  <= head_d;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_packet_frame_ctrl.sv
// tb_packet_frame_ctrl: directed bench with two instances (MSB-first and
// LSB-first packing) driven by the same byte stream.
module tb_packet_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_vld, frame_err, pkt_ready;
  logic [7:0]  byte_data;
  logic        pkt_valid, resync, busy;
  logic [31:0] pkt_data;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;
  logic        pkt_valid_l, resync_l, busy_l;
  logic [31:0] pkt_data_l;
  logic [2:0]  fifo_level_l;
  logic [7:0]  drop_cnt_l;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resync = 0;
  int n_wide   = 0;
  logic resync_prev = 1'b0;
  logic [31:0] rx_q[$];
  logic [31:0] rx_l[$];

  packet_frame_ctrl #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .reset(reset), .byte_vld(byte_vld), .byte_data(byte_data),
    .frame_err(frame_err), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .resync(resync), .busy(busy)
  );

  packet_frame_ctrl #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .byte_vld(byte_vld), .byte_data(byte_data),
    .frame_err(frame_err), .pkt_valid(pkt_valid_l), .pkt_data(pkt_data_l),
    .pkt_ready(pkt_ready), .fifo_level(fifo_level_l), .drop_cnt(drop_cnt_l),
    .resync(resync_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  // collect accepted packets and resync pulses away from the active edge
  always @(negedge clk) begin
    if (pkt_valid && pkt_ready)   rx_q.push_back(pkt_data);
    if (pkt_valid_l && pkt_ready) rx_l.push_back(pkt_data_l);
    if (resync) n_resync++;
    if (resync && resync_prev) n_wide++;
    resync_prev = resync;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (rx_q.size() > i) ? rx_q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk); #2;
    byte_vld = 1'b1; byte_data = b; frame_err = err;
    @(posedge clk); #2;
    byte_vld = 1'b0; frame_err = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [7:0] t1_bytes [4];
    t1_bytes[0] = 8'h3B; t1_bytes[1] = 8'h55; t1_bytes[2] = 8'h0F; t1_bytes[3] = 8'h0F;
    reset = 1'b0; byte_vld = 1'b0; byte_data = 8'h00; frame_err = 1'b0; pkt_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", pkt_valid, 0);
    check("rst_data", pkt_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_resync", resync, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #2 reset = 1'b1;

    // 1/2: single packet spaced 320 cycles, both packing orders, latency
    pkt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(t1_bytes[i], 1'b0);
      if (i < 3) repeat (319) @(posedge clk);
    end
    @(negedge clk);
    check("t1_commit_valid", pkt_valid, 0);
    check("t1_commit_busy", busy, 1);
    @(negedge clk);
    check("t1_lat_valid", pkt_valid, 1);
    check("t1_lat_data", pkt_data, 32'h3B550F0F);
    idle(10);
    check("t1_count", rx_q.size(), 1);
    check("t1_pkt", rx_at(0), 32'h3B550F0F);
    check("t2_pkt_lsb", (rx_l.size() > 0) ? rx_l[0] : 32'hDEAD_DEAD, 32'h0F0F553B);
    check("t1_level", fifo_level, 0);
    check("t1_drop", drop_cnt, 0);
    check("t1_resync", n_resync, 0);

    // 3: timeout after two bytes, then a clean packet
    rx_q.delete(); rx_l.delete(); r0 = n_resync;
    send_byte(8'h3B, 1'b0);
    send_byte(8'h55, 1'b0);
    repeat (1024) @(negedge clk);
    check("t3_pre_to_busy", busy, 1);
    check("t3_pre_to_resync", resync, 0);
    @(negedge clk);
    check("t3_to_resync", resync, 1);
    check("t3_to_busy", busy, 0);
    @(negedge clk);
    check("t3_resync_end", resync, 0);
    idle(80);
    send_pkt(32'h55CCFFF0);
    idle(10);
    check("t3_resync_cnt", n_resync - r0, 1);
    check("t3_count", rx_q.size(), 1);
    check("t3_pkt", rx_at(0), 32'h55CCFFF0);

    // 4: FIFO fill with pkt_ready low, drops, then drain in order
    rx_q.delete(); rx_l.delete();
    pkt_ready = 1'b0;
    for (int p = 1; p <= 6; p++) send_pkt(32'(p));
    idle(5);
    check("t4_level_full", fifo_level, 4);
    check("t4_drop", drop_cnt, 2);
    check("t4_head_valid", pkt_valid, 1);
    check("t4_head_hold", pkt_data, 32'h1);
    pkt_ready = 1'b1;
    idle(10);
    check("t4_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_order", rx_at(i), 32'(i + 1));
    check("t4_level_empty", fifo_level, 0);
    check("t4_valid_empty", pkt_valid, 0);

    // 5: frame error on third byte, then a good packet
    rx_q.delete(); rx_l.delete(); r0 = n_resync;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b1);
    idle(3);
    check("t5_resync_cnt", n_resync - r0, 1);
    check("t5_busy", busy, 0);
    send_pkt(32'h11223344);
    idle(10);
    check("t5_count", rx_q.size(), 1);
    check("t5_pkt", rx_at(0), 32'h11223344);

    // back-to-back bytes: fifth byte lands in the commit cycle
    rx_q.delete(); rx_l.delete(); r0 = n_resync;
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) begin
      byte_vld = 1'b1; byte_data = 8'(i + 1);
      @(posedge clk); #2;
    end
    byte_vld = 1'b0;
    idle(10);
    check("b2b_count", rx_q.size(), 2);
    check("b2b_pkt0", rx_at(0), 32'h01020304);
    check("b2b_pkt1", rx_at(1), 32'h05060708);
    check("b2b_resync", n_resync - r0, 0);

    // 6: asynchronous reset with a partial packet and two queued packets
    pkt_ready = 1'b0; r0 = n_resync;
    send_pkt(32'hAABBCCDD);
    send_pkt(32'h12345678);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    idle(2);
    check("t6_pre_level", fifo_level, 2);
    check("t6_pre_busy", busy, 1);
    #3 reset = 1'b0;
    #1;
    check("t6_rst_valid", pkt_valid, 0);
    check("t6_rst_data", pkt_data, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_drop", drop_cnt, 0);
    idle(3);
    reset = 1'b1;
    rx_q.delete(); rx_l.delete();
    pkt_ready = 1'b1;
    send_pkt(32'h9ABCDEF0);
    idle(10);
    check("t6_count", rx_q.size(), 1);
    check("t6_pkt", rx_at(0), 32'h9ABCDEF0);
    check("t6_no_resync", n_resync - r0, 0);

    // drop counter saturation with a stalled sink
    pkt_ready = 1'b0;
    for (int p = 0; p < 264; p++) send_pkt(32'(p + 32'h100));
    idle(5);
    check("sat_drop", drop_cnt, 255);
    check("sat_level", fifo_level, 4);
    check("sat_head", pkt_data, 32'h100);

    check("resync_width", n_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
